// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, instruction register and
// branch/halt control in front of a combinational program memory.
//
// state    | meaning
// S_RUN    | fetching; branch/halt accepted when ir is live and not stalled
// S_HALTED | frozen with ir_valid=0 until nReset

module fetch_unit #(
  parameter int P_SIZE = 6,
  parameter int I_SIZE = 24
) (
  input  logic              clk,
  input  logic              nReset,
  output logic [P_SIZE-1:0] address,
  input  logic [I_SIZE-1:0] instruction,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [P_SIZE-1:0] branch_value,
  input  logic              halt,
  output logic [I_SIZE-1:0] ir,
  output logic [P_SIZE-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [P_SIZE-1:0] pc;
  logic [P_SIZE-1:0] target;
  logic              accept;
  logic              take_halt;
  logic              take_branch;
  logic              seq_fetch;

  // A request is only meaningful against a live instruction in IR.
  always_comb begin
    accept      = (state == S_RUN) && !stall && ir_valid;
    take_halt   = accept && halt;
    take_branch = accept && branch_en && !halt;
    seq_fetch   = (state == S_RUN) && !stall && !take_halt && !take_branch;
  end

  // Same-width add gives sign extension and the modulo wrap for free.
  always_comb begin
    if (branch_rel) begin
      target = ir_pc + branch_value;
    end else begin
      target = branch_value;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (take_halt) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    halted  = (state == S_HALTED);
    address = pc;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc          <= '0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (take_halt) begin
      ir_valid <= 1'b0;
    end else if (take_branch) begin
      pc       <= target;
      ir_valid <= 1'b0;
    end else if (seq_fetch) begin
      ir       <= instruction;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      pc       <= pc + P_SIZE'(1);
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized run against a
// behavioural model, and a long free run for counter saturation and pc wrap.

module tb_fetch_unit;
  localparam int P = 6;
  localparam int I = 24;
  localparam int SAT_CYCLES = 65600;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         stall = 1'b0;
  logic         branch_en = 1'b0;
  logic         branch_rel = 1'b0;
  logic         halt = 1'b0;
  logic [P-1:0] branch_value = '0;
  logic [P-1:0] address;
  logic [P-1:0] ir_pc;
  logic [I-1:0] instruction;
  logic [I-1:0] ir;
  logic         ir_valid;
  logic         halted;
  logic [15:0]  fetch_count;

  logic [I-1:0] mem [64];

  int compared = 0;
  int mismatched = 0;

  int m_pc, m_ir, m_irpc, m_cnt;
  bit m_valid, m_halted;

  always #5 clk = ~clk;

  assign instruction = mem[address];

  fetch_unit #(.P_SIZE(P), .I_SIZE(I)) dut (
    .clk(clk), .nReset(nReset), .address(address), .instruction(instruction),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_value(branch_value), .halt(halt), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    bit rst; bit st; bit be; bit rel; int bv; bit hl;
    int e_irpc; bit e_v; bit e_h; int e_addr; int e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit st, bit be, bit rel, int bv, bit hl,
                              int e_irpc, bit e_v, bit e_h, int e_addr, int e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.be = be; v.rel = rel; v.bv = bv; v.hl = hl;
    v.e_irpc = e_irpc; v.e_v = e_v; v.e_h = e_h; v.e_addr = e_addr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_irpc = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
  endtask

  // Reference behaviour of one clock edge, from the current inputs.
  task automatic model_step();
    int off;
    if (m_halted || stall) return;
    if (m_valid && halt) begin
      m_halted = 1; m_valid = 0;
    end else if (m_valid && branch_en) begin
      if (branch_rel) begin
        off = (int'(branch_value) >= 32) ? int'(branch_value) - 64 : int'(branch_value);
        m_pc = (m_irpc + off + 64) % 64;
      end else begin
        m_pc = int'(branch_value);
      end
      m_valid = 0;
    end else begin
      m_ir = int'(mem[m_pc]);
      m_irpc = m_pc;
      m_valid = 1;
      m_pc = (m_pc + 1) % 64;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " ir"}, 32'(ir), 32'(m_ir));
    chk({tag, " ir_pc"}, 32'(ir_pc), 32'(m_irpc));
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'(m_valid));
    chk({tag, " halted"}, 32'(halted), 32'(m_halted));
    chk({tag, " address"}, 32'(address), 32'(m_pc));
    chk({tag, " fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    nReset = 1'b0;
    #2;
    chk("async_rst address", 32'(address), 32'd0);
    chk("async_rst halted", 32'(halted), 32'd0);
    chk("async_rst ir_valid", 32'(ir_valid), 32'd0);
    nReset = 1'b1;
    #1;
    model_reset();
  endtask

  initial begin
    vec_t v;
    int bad, wraps;
    logic [P-1:0] prev_pc;

    for (int i = 0; i < 64; i++) mem[i] = I'(i * 3);

    //              rst st be rel bv hl   irpc v h addr cnt
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    0, 1, 0,  1,  1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    1, 1, 0,  2,  2));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    2, 1, 0,  3,  3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    3, 1, 0,  4,  4));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,    0, 1, 0,  1,  1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    1, 1, 0,  2,  2));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    2, 1, 0,  3,  3));
    vecs.push_back(mk(0, 0, 1, 0, 40, 0,    2, 0, 0, 40,  3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   40, 1, 0, 41,  4));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   41, 1, 0, 42,  5));
    vecs.push_back(mk(0, 0, 1, 0,  5, 0,   41, 0, 0,  5,  5));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    5, 1, 0,  6,  6));
    vecs.push_back(mk(0, 0, 1, 1, 61, 0,    5, 0, 0,  2,  6));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    2, 1, 0,  3,  7));
    vecs.push_back(mk(0, 0, 1, 0, 62, 0,    2, 0, 0, 62,  7));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   62, 1, 0, 63,  8));
    vecs.push_back(mk(0, 0, 1, 1,  4, 0,   62, 0, 0,  2,  8));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    2, 1, 0,  3,  9));
    vecs.push_back(mk(0, 0, 1, 0,  7, 0,    2, 0, 0,  7,  9));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    7, 1, 0,  8, 10));
    vecs.push_back(mk(0, 1, 1, 0, 20, 0,    7, 1, 0,  8, 10));
    vecs.push_back(mk(0, 1, 1, 0, 20, 0,    7, 1, 0,  8, 10));
    vecs.push_back(mk(0, 1, 1, 0, 20, 0,    7, 1, 0,  8, 10));
    vecs.push_back(mk(0, 0, 1, 0, 20, 0,    7, 0, 0, 20, 10));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   20, 1, 0, 21, 11));
    vecs.push_back(mk(0, 0, 1, 0,  9, 0,   20, 0, 0,  9, 11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    9, 1, 0, 10, 12));
    vecs.push_back(mk(0, 0, 1, 0, 30, 1,    9, 0, 1, 10, 12));
    vecs.push_back(mk(0, 0, 0, 0, 30, 0,    9, 0, 1, 10, 12));
    vecs.push_back(mk(0, 0, 1, 0, 30, 0,    9, 0, 1, 10, 12));
    vecs.push_back(mk(0, 0, 0, 0, 30, 1,    9, 0, 1, 10, 12));
    vecs.push_back(mk(0, 1, 1, 0, 30, 0,    9, 0, 1, 10, 12));
    vecs.push_back(mk(0, 0, 1, 1,  5, 0,    9, 0, 1, 10, 12));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,    0, 1, 0,  1,  1));
    vecs.push_back(mk(0, 0, 1, 0, 50, 0,    0, 0, 0, 50,  1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1,   50, 1, 0, 51,  2));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   51, 1, 0, 52,  3));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,   51, 1, 0, 52,  3));
    vecs.push_back(mk(0, 0, 1, 0, 63, 0,   51, 0, 0, 63,  3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,   63, 1, 0,  0,  4));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,    0, 1, 0,  1,  5));

    repeat (2) @(posedge clk);
    #1;
    chk("reset ir", 32'(ir), 32'd0);
    chk("reset ir_pc", 32'(ir_pc), 32'd0);
    chk("reset ir_valid", 32'(ir_valid), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset address", 32'(address), 32'd0);
    chk("reset fetch_count", 32'(fetch_count), 32'd0);
    nReset = 1'b1;

    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.rst) pulse_reset();
      stall = v.st; branch_en = v.be; branch_rel = v.rel;
      branch_value = P'(v.bv); halt = v.hl;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d ir_pc", k), 32'(ir_pc), 32'(v.e_irpc));
      chk($sformatf("row%0d ir", k), 32'(ir), 32'(I'(v.e_irpc * 3)));
      chk($sformatf("row%0d ir_valid", k), 32'(ir_valid), 32'(v.e_v));
      chk($sformatf("row%0d halted", k), 32'(halted), 32'(v.e_h));
      chk($sformatf("row%0d address", k), 32'(address), 32'(v.e_addr));
      chk($sformatf("row%0d fetch_count", k), 32'(fetch_count), 32'(v.e_cnt));
    end

    for (int i = 0; i < 64; i++) mem[i] = I'($urandom);
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_en = ($urandom_range(0, 2) == 0);
      branch_rel = 1'($urandom_range(0, 1));
      branch_value = P'($urandom_range(0, 63));
      halt = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      model_step();
      @(posedge clk);
      #1;
      chk_model($sformatf("rand%0d", n));
    end

    stall = 1'b0; branch_en = 1'b0; halt = 1'b0; branch_rel = 1'b0;
    pulse_reset();
    bad = 0;
    wraps = 0;
    prev_pc = ir_pc;
    for (int n = 1; n <= SAT_CYCLES; n++) begin
      model_step();
      @(posedge clk);
      #1;
      if (ir_pc !== P'(m_irpc) || ir !== I'(m_ir) || ir_valid !== 1'b1 ||
          fetch_count !== 16'(m_cnt)) bad++;
      if (n > 1 && prev_pc == 6'd63 && ir_pc == 6'd0) wraps++;
      prev_pc = ir_pc;
      if (n == 65534) chk("sat fetch_count before top", 32'(fetch_count), 32'hFFFE);
    end
    chk("sat fetch_count", 32'(fetch_count), 32'hFFFF);
    chk("sat cycles off model", 32'(bad), 32'd0);
    chk("sat ir_pc wraps", 32'(wraps), 32'((SAT_CYCLES - 1) / 64));
    chk("sat ir_valid", 32'(ir_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
